// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and
// elaboration-time helpers for baud division and counter widths.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_baud_div(input int period_ns, input int baud);
        longint prod;
        prod = longint'(period_ns) * longint'(baud);
        return int'((longint'(1_000_000_000) + prod / 2) / prod);
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: free-running modulo-DIV counter with a synchronous
// restart, emitting a one-clock bit_end pulse on the last clock of each bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int CW = clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last;

    assign last      = (cnt_q == CW'(DIV - 1));
    assign bit_end_o = last && !restart_i;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_burst.sv
// Multi-byte UART transmitter: latches up to BYTE_NUM bytes on START and
// serialises them with a configurable frame, gap, byte order and abort.
module uart_tx_burst
    import uart_pkg::*;
#(
    parameter int SYS_CLK_PERIOD    = 20,
    parameter int BAUD_RATE         = 115200,
    parameter int BYTE_NUM          = 8,
    parameter int DATA_BITS         = 8,
    parameter int PARITY            = 0,
    parameter int STOP_BITS         = 1,
    parameter int GAP_BITS          = 0,
    parameter int BYTE_ORDER        = 0,
    parameter int FINISH_PERIOD_NUM = 20
) (
    input  logic                              CLK_I,
    input  logic                              RSTN_I,
    input  logic [8*BYTE_NUM-1:0]             DATA_I,
    input  logic [clog2(BYTE_NUM+1)-1:0]      LEN_I,
    input  logic                              START_I,
    input  logic                              ABORT_I,
    output logic                              SDATA_O,
    output logic                              BUSY_O,
    output logic                              FINISH_O,
    output logic [clog2(BYTE_NUM+1)-1:0]      BYTE_CNT_O
);

    localparam int   DIV    = calc_baud_div(SYS_CLK_PERIOD, BAUD_RATE);
    localparam int   LW     = clog2(BYTE_NUM + 1);
    localparam logic PAR_EN = (PARITY != PAR_NONE);

    if (DIV < 4) begin : g_div_check
        $fatal(1, "uart_tx_burst: baud divider must be at least 4");
    end

    logic [2:0]            state_q, state_d;
    logic [8*BYTE_NUM-1:0] data_q, data_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         sent_q, sent_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  abort_q, abort_d;
    logic                  sdata_q, sdata_d;
    logic                  busy_q, busy_d;
    logic                  finish_q, finish_d;

    logic          accept;
    logic          tick;
    logic          abort_pend;
    logic [LW-1:0] eff_len;
    logic [LW-1:0] cur_idx;
    logic [7:0]    cur_byte;
    logic [7:0]    cur_data;

    // busy_q also gates accept so START is ignored until FINISH_O has fallen.
    assign accept     = (state_q == ST_IDLE) && START_I && !busy_q;
    assign abort_pend = abort_q || ABORT_I;
    assign eff_len    = ((LEN_I == '0) || (LEN_I > LW'(BYTE_NUM))) ? LW'(BYTE_NUM) : LEN_I;
    assign cur_idx    = (BYTE_ORDER != 0) ? (len_q - sent_q - LW'(1)) : sent_q;
    assign cur_data   = cur_byte & 8'((1 << DATA_BITS) - 1);

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < BYTE_NUM; i++) begin
            if (cur_idx == LW'(i)) begin
                cur_byte = data_q[8*i +: 8];
            end
        end
    end

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud (
        .clk_i    (CLK_I),
        .rst_ni   (RSTN_I),
        .restart_i(accept),
        .bit_end_o(tick)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        sent_d  = sent_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = DATA_I;
                    len_d   = eff_len;
                    sent_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    shift_d = cur_data;
                    par_d   = (PARITY == PAR_ODD) ? ~^cur_data : ^cur_data;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == 16'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (cnt_q == 16'(STOP_BITS - 1)) begin
                        cnt_d  = '0;
                        sent_d = sent_q + LW'(1);
                        if ((sent_d < len_q) && !abort_pend) begin
                            state_d = (GAP_BITS > 0) ? ST_GAP : ST_START;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (cnt_q == 16'(GAP_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = abort_pend ? ST_DONE : ST_START;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                if (cnt_q == 16'(FINISH_PERIOD_NUM - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs lag the state by one clock so the line changes one edge after accept.
    always_comb begin
        abort_d  = (state_d == ST_IDLE) ? 1'b0 : (abort_q || ((state_q != ST_IDLE) && ABORT_I));
        busy_d   = (state_q != ST_IDLE);
        finish_d = (state_q == ST_DONE);
        case (state_q)
            ST_START:  sdata_d = 1'b0;
            ST_DATA:   sdata_d = shift_q[0];
            ST_PARITY: sdata_d = par_q;
            default:   sdata_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            len_q    <= '0;
            sent_q   <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            abort_q  <= 1'b0;
            sdata_q  <= 1'b1;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            len_q    <= len_d;
            sent_q   <= sent_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            abort_q  <= abort_d;
            sdata_q  <= sdata_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign SDATA_O    = sdata_q;
    assign BUSY_O     = busy_q;
    assign FINISH_O   = finish_q;
    assign BYTE_CNT_O = sent_q;

endmodule

// File: tb/tb_uart_tx_burst.sv
// Directed bench for uart_tx_burst: five instances cover default 8N1, 7E2,
// inter-character gaps with both byte orders, abort and reset behaviour.
module tb_uart_tx_burst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] dat [5];
    logic [3:0]  len [5];
    logic        st  [5];
    logic        ab  [5];
    logic        sd  [5];
    logic        bz  [5];
    logic        fn  [5];
    logic [3:0]  bc  [5];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sel   = 0;

    always #10 clk = ~clk;

    uart_tx_burst u0 (
        .CLK_I(clk), .RSTN_I(rst_n), .DATA_I(dat[0]), .LEN_I(len[0]),
        .START_I(st[0]), .ABORT_I(ab[0]), .SDATA_O(sd[0]), .BUSY_O(bz[0]),
        .FINISH_O(fn[0]), .BYTE_CNT_O(bc[0])
    );

    uart_tx_burst #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .CLK_I(clk), .RSTN_I(rst_n), .DATA_I(dat[1]), .LEN_I(len[1]),
        .START_I(st[1]), .ABORT_I(ab[1]), .SDATA_O(sd[1]), .BUSY_O(bz[1]),
        .FINISH_O(fn[1]), .BYTE_CNT_O(bc[1])
    );

    uart_tx_burst #(.GAP_BITS(2), .BYTE_ORDER(0)) u2 (
        .CLK_I(clk), .RSTN_I(rst_n), .DATA_I(dat[2]), .LEN_I(len[2]),
        .START_I(st[2]), .ABORT_I(ab[2]), .SDATA_O(sd[2]), .BUSY_O(bz[2]),
        .FINISH_O(fn[2]), .BYTE_CNT_O(bc[2])
    );

    // 5 Mbit/s at 20 ns gives a 10-clock bit to keep the long scenarios short.
    uart_tx_burst #(.BAUD_RATE(5_000_000), .GAP_BITS(2), .BYTE_ORDER(1)) u3 (
        .CLK_I(clk), .RSTN_I(rst_n), .DATA_I(dat[3]), .LEN_I(len[3]),
        .START_I(st[3]), .ABORT_I(ab[3]), .SDATA_O(sd[3]), .BUSY_O(bz[3]),
        .FINISH_O(fn[3]), .BYTE_CNT_O(bc[3])
    );

    uart_tx_burst #(.BAUD_RATE(5_000_000)) u4 (
        .CLK_I(clk), .RSTN_I(rst_n), .DATA_I(dat[4]), .LEN_I(len[4]),
        .START_I(st[4]), .ABORT_I(ab[4]), .SDATA_O(sd[4]), .BUSY_O(bz[4]),
        .FINISH_O(fn[4]), .BYTE_CNT_O(bc[4])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic waitUntil(input int t);
        if (t > cyc) tick(t - cyc);
    endtask

    task automatic applyStimulus(input int which);
        sel       = which;
        st[which] = 1'b1;
        tick(1);
        st[which] = 1'b0;
        cyc       = 0;
    endtask

    task automatic checkFrame(input string tag, input int base, input int div,
                              input logic [15:0] frame, input int jlo, input int jhi);
        for (int j = jlo; j <= jhi; j++) begin
            waitUntil(base + 1 + j * div);
            chk({tag, "_first"}, 16'(sd[sel]), 16'(frame[j]));
            waitUntil(base + (j + 1) * div);
            chk({tag, "_last"}, 16'(sd[sel]), 16'(frame[j]));
        end
    endtask

    task automatic checkOutput(input string tag, input int t, input int cnt);
        waitUntil(t - 1);
        chk({tag, "_fin_pre"}, 16'(fn[sel]), 16'd0);
        waitUntil(t);
        chk({tag, "_fin_rise"}, 16'(fn[sel]), 16'd1);
        chk({tag, "_busy"}, 16'(bz[sel]), 16'd1);
        chk({tag, "_cnt"}, 16'(bc[sel]), 16'(cnt));
        waitUntil(t + 19);
        chk({tag, "_fin_hold"}, 16'(fn[sel]), 16'd1);
        waitUntil(t + 20);
        chk({tag, "_fin_fall"}, 16'(fn[sel]), 16'd0);
        chk({tag, "_busy_fall"}, 16'(bz[sel]), 16'd0);
        chk({tag, "_line_idle"}, 16'(sd[sel]), 16'd1);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            dat[i] = '0;
            len[i] = 4'd1;
            st[i]  = 1'b0;
            ab[i]  = 1'b0;
        end
        rst_n = 1'b0;
        tick(3);
        chk("rst_line", 16'(sd[0]), 16'd1);
        chk("rst_busy", 16'(bz[0]), 16'd0);
        chk("rst_fin", 16'(fn[0]), 16'd0);
        chk("rst_cnt", 16'(bc[0]), 16'd0);
        rst_n = 1'b1;
        tick(3);

        // Single 8N1 byte 0x55 at DIV=434.
        dat[0] = 64'h55;
        len[0] = 4'd1;
        applyStimulus(0);
        chk("t1_line_accept", 16'(sd[0]), 16'd1);
        chk("t1_busy_accept", 16'(bz[0]), 16'd0);
        checkFrame("t1", 0, 434, 16'h2AA, 0, 9);
        checkOutput("t1", 4341, 1);
        tick(5);

        // Re-pulsed START mid-burst and during FINISH must change nothing.
        dat[0] = 64'hA3;
        applyStimulus(0);
        checkFrame("t2a", 0, 434, 16'h346, 0, 1);
        waitUntil(1000);
        dat[0] = 64'hFF;
        st[0]  = 1'b1;
        tick(1);
        st[0]  = 1'b0;
        checkFrame("t2b", 0, 434, 16'h346, 2, 9);
        waitUntil(4340);
        chk("t2_fin_pre", 16'(fn[0]), 16'd0);
        waitUntil(4341);
        chk("t2_fin_rise", 16'(fn[0]), 16'd1);
        waitUntil(4345);
        st[0] = 1'b1;
        tick(1);
        st[0] = 1'b0;
        waitUntil(4361);
        chk("t2_fin_fall", 16'(fn[0]), 16'd0);
        chk("t2_busy_fall", 16'(bz[0]), 16'd0);
        waitUntil(4400);
        chk("t2_no_restart_line", 16'(sd[0]), 16'd1);
        chk("t2_no_restart_busy", 16'(bz[0]), 16'd0);
        tick(5);

        // Asynchronous reset in the middle of a start bit.
        dat[0] = 64'h0F;
        applyStimulus(0);
        waitUntil(200);
        chk("t3_start_bit", 16'(sd[0]), 16'd0);
        chk("t3_busy", 16'(bz[0]), 16'd1);
        rst_n = 1'b0;
        #2;
        chk("t3_async_line", 16'(sd[0]), 16'd1);
        chk("t3_async_busy", 16'(bz[0]), 16'd0);
        chk("t3_async_fin", 16'(fn[0]), 16'd0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        chk("t3_cnt", 16'(bc[0]), 16'd0);

        // LEN_I=0 sends all eight bytes.
        dat[0] = 64'h8877665544332211;
        len[0] = 4'd0;
        applyStimulus(0);
        checkFrame("t4_b0", 0, 434, 16'h222, 0, 9);
        checkFrame("t4_b7", 7 * 4340, 434, 16'h310, 0, 9);
        checkOutput("t4", 34721, 8);
        tick(5);

        // 7E2: 0xC1 sends 0x41 with parity 0, then 0x43 with parity 1.
        dat[1] = 64'h43C1;
        len[1] = 4'd2;
        applyStimulus(1);
        checkFrame("t5_b0", 0, 434, 16'h682, 0, 10);
        checkFrame("t5_b1", 4774, 434, 16'h786, 0, 10);
        checkOutput("t5", 9549, 2);
        tick(5);

        // Two-bit gaps, byte index 0 first.
        dat[2] = 64'h112233;
        len[2] = 4'd3;
        applyStimulus(2);
        checkFrame("t6_b0", 0, 434, 16'h266, 0, 9);
        waitUntil(4341);
        chk("t6_gap_first", 16'(sd[2]), 16'd1);
        waitUntil(5208);
        chk("t6_gap_last", 16'(sd[2]), 16'd1);
        checkFrame("t6_b1", 5208, 434, 16'h244, 0, 9);
        checkFrame("t6_b2", 10416, 434, 16'h222, 0, 9);
        checkOutput("t6", 14757, 3);
        tick(5);

        // Two-bit gaps, highest index first, DIV=10.
        dat[3] = 64'h112233;
        len[3] = 4'd3;
        applyStimulus(3);
        checkFrame("t7_b0", 0, 10, 16'h222, 0, 9);
        checkFrame("t7_b1", 120, 10, 16'h244, 0, 9);
        checkFrame("t7_b2", 240, 10, 16'h266, 0, 9);
        checkOutput("t7", 341, 3);
        tick(5);

        // ABORT in IDLE, and together with START, is ignored.
        ab[4] = 1'b1;
        tick(1);
        ab[4] = 1'b0;
        tick(2);
        dat[4] = 64'hCCBBAA;
        len[4] = 4'd2;
        sel    = 4;
        st[4]  = 1'b1;
        ab[4]  = 1'b1;
        tick(1);
        st[4]  = 1'b0;
        ab[4]  = 1'b0;
        cyc    = 0;
        checkOutput("t8", 201, 2);
        tick(5);

        // ABORT during byte 2 data: byte 2 completes, byte 3 never starts.
        len[4] = 4'd3;
        applyStimulus(4);
        waitUntil(135);
        ab[4] = 1'b1;
        tick(1);
        ab[4] = 1'b0;
        checkFrame("t9_b1", 100, 10, 16'h376, 4, 9);
        checkOutput("t9", 201, 2);
        waitUntil(260);
        chk("t9_no_byte3", 16'(sd[4]), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
